// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: synchroniser, per-channel stability counter, edge and long-press one-shots.
// raw->clean latency is SYNC_STAGES+MAX_COUNT edges; pulses register alongside clean; no backpressure.
module debouncer_multi #(
  parameter int CHANNELS    = 4,
  parameter int MAX_COUNT   = 240000,
  parameter int LONG_COUNT  = 24000000,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_signal,
  output logic [CHANNELS-1:0] clean_signal,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_press,
  output logic                any_change
);

  localparam int CW = $clog2(MAX_COUNT + 1);
  localparam int LW = $clog2(LONG_COUNT + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(MAX_COUNT - 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_COUNT - 1);
  localparam logic [LW-1:0] LP_MAX  = LW'(LONG_COUNT);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] accept;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {CHANNELS{INIT_LEVEL}};
      end
    end else begin
      sync_q[0] <= raw_signal;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CW-1:0] db_cnt;
      logic [LW-1:0] lp_cnt;
      logic          clean_q;
      logic          rise_q;
      logic          fall_q;
      logic          long_q;

      // Accept on the MAX_COUNT-th consecutive cycle of disagreement.
      assign accept[i] = (sync[i] != clean_q) && (db_cnt == DB_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_cnt  <= '0;
          clean_q <= INIT_LEVEL;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          rise_q <= accept[i] & sync[i];
          fall_q <= accept[i] & ~sync[i];
          if (sync[i] == clean_q) begin
            db_cnt <= '0;
          end else if (accept[i]) begin
            clean_q <= sync[i];
            db_cnt  <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
      end

      // Saturating hold counter; the one-shot fires only on the LAST->MAX step.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lp_cnt <= '0;
          long_q <= 1'b0;
        end else begin
          long_q <= clean_q && (lp_cnt == LP_LAST);
          if (!clean_q) begin
            lp_cnt <= '0;
          end else if (lp_cnt != LP_MAX) begin
            lp_cnt <= lp_cnt + 1'b1;
          end
        end
      end

      assign clean_signal[i] = clean_q;
      assign rise_pulse[i]   = rise_q;
      assign fall_pulse[i]   = fall_q;
      assign long_press[i]   = long_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |accept;
    end
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: event scoreboard keyed on cycle number plus level checks.
module tb_debouncer_multi;
  localparam int CH = 4;
  localparam int MC = 4;
  localparam int LC = 10;
  localparam int SS = 2;
  localparam int LAT = SS + MC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] raw = '0;
  logic [CH-1:0] clean_signal, rise_pulse, fall_pulse, long_press;
  logic          any_change;

  debouncer_multi #(
    .CHANNELS(CH), .MAX_COUNT(MC), .LONG_COUNT(LC), .SYNC_STAGES(SS), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_signal(raw),
    .clean_signal(clean_signal), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .long_press(long_press), .any_change(any_change)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int            c;
    logic [CH-1:0] r;
    logic [CH-1:0] f;
    logic [CH-1:0] l;
  } ev_t;
  ev_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected events are kept sorted by cycle; same-cycle events merge.
  function automatic void expect_ev(input int c, input logic [CH-1:0] r,
                                    input logic [CH-1:0] f, input logic [CH-1:0] l);
    ev_t e;
    int  pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].c == c) begin
        e = sb[i];
        e.r = e.r | r;
        e.f = e.f | f;
        e.l = e.l | l;
        sb[i] = e;
        return;
      end
      if (sb[i].c > c) begin
        pos = i;
        break;
      end
    end
    e.c = c;
    e.r = r;
    e.f = f;
    e.l = l;
    sb.insert(pos, e);
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if ((|rise_pulse) || (|fall_pulse) || (|long_press) || any_change) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {19'd0, rise_pulse, fall_pulse, long_press, any_change}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ev_cycle", cyc, e.c);
        check("ev_rise", rise_pulse, e.r);
        check("ev_fall", fall_pulse, e.f);
        check("ev_long", long_press, e.l);
        check("ev_any", any_change, |(e.r | e.f));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int r;

  initial begin
    cycles(3);
    check("rst_clean", clean_signal, 0);
    check("rst_pulses", {rise_pulse, fall_pulse, long_press, any_change}, 0);
    rst_n = 1'b1;
    cycles(2);

    // Clean press on channel 0
    raw[0] = 1'b1;
    expect_ev(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
    cycles(LAT - 1);
    check("t1_early", clean_signal, 4'b0000);
    cycles(1);
    check("t1_clean", clean_signal, 4'b0001);
    cycles(1);

    // Release channel 0 before the long-press threshold
    raw[0] = 1'b0;
    expect_ev(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
    cycles(LAT - 1);
    check("t3_early", clean_signal, 4'b0001);
    cycles(1);
    check("t3_clean", clean_signal, 4'b0000);
    cycles(3);

    // Bounce on channel 1: runs of 3 never reach acceptance
    raw[1] = 1'b1; cycles(3);
    raw[1] = 1'b0; cycles(1);
    raw[1] = 1'b1; cycles(3);
    raw[1] = 1'b0; cycles(8);
    check("t2_bounce", clean_signal, 4'b0000);
    raw[1] = 1'b1;
    expect_ev(cyc + LAT, 4'b0010, 4'b0000, 4'b0000);
    cycles(LAT);
    check("t2_clean", clean_signal, 4'b0010);
    raw[1] = 1'b0;
    expect_ev(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
    cycles(8);

    // Long press on channel 2, held well past the threshold, then re-pressed
    raw[2] = 1'b1;
    r = cyc + LAT;
    expect_ev(r, 4'b0100, 4'b0000, 4'b0000);
    expect_ev(r + LC, 4'b0000, 4'b0000, 4'b0100);
    cycles(LAT + 30);
    check("t4_held", clean_signal, 4'b0100);
    raw[2] = 1'b0;
    expect_ev(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
    cycles(8);
    check("t4_released", clean_signal, 4'b0000);
    raw[2] = 1'b1;
    r = cyc + LAT;
    expect_ev(r, 4'b0100, 4'b0000, 4'b0000);
    expect_ev(r + LC, 4'b0000, 4'b0000, 4'b0100);
    cycles(LAT + 12);
    raw[2] = 1'b0;
    expect_ev(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
    cycles(8);

    // All channels at once
    raw = 4'b1111;
    r = cyc + LAT;
    expect_ev(r, 4'b1111, 4'b0000, 4'b0000);
    expect_ev(r + LC, 4'b0000, 4'b0000, 4'b1111);
    cycles(LAT);
    check("t5_clean", clean_signal, 4'b1111);
    cycles(12);
    raw = 4'b1110;
    expect_ev(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
    cycles(8);
    check("t5_partial", clean_signal, 4'b1110);

    // Reset while channel 0's debounce count sits at 2
    raw[0] = 1'b1;
    cycles(SS + 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_clean", clean_signal, 4'b0000);
    check("t6_rst_pulses", {rise_pulse, fall_pulse, long_press, any_change}, 0);
    cycles(2);
    check("t6_in_rst", clean_signal, 4'b0000);
    rst_n = 1'b1;
    r = cyc + LAT;
    expect_ev(r, 4'b1111, 4'b0000, 4'b0000);
    expect_ev(r + LC, 4'b0000, 4'b0000, 4'b1111);
    cycles(LAT - 1);
    check("t6_no_early", clean_signal, 4'b0000);
    cycles(1);
    check("t6_clean", clean_signal, 4'b1111);
    cycles(15);
    raw = 4'b0000;
    expect_ev(cyc + LAT, 4'b0000, 4'b1111, 4'b0000);
    cycles(LAT);
    check("t6_released", clean_signal, 4'b0000);
    cycles(4);

    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
